// File: rtl/pulse_rr_sched_pkg.sv
// pulse_rr_sched_pkg
// Shared types and helpers for the round-robin LED pulse scheduler.
//   sched_state_t  : scheduler FSM encoding (IDLE, PULSE, GAP)
//   COUNT_W        : width of the per-requester served counters and count_o
//   onehot_to_idx  : converts a one-hot vector (up to 8 bits) to a binary index
package pulse_rr_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } sched_state_t;

  localparam int COUNT_W = 8;

  // OR-reduction of the set bit positions; exact for a one-hot input,
  // returns 0 for an all-zero input.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pulse_rr_sched_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin arbiter. Searches req starting at last+1 with
// wrap-around and reports the first set bit.
// Ports:
//   req   : pending request vector, bit k belongs to requester k
//   last  : index of the most recently granted requester
//   valid : high when any request is present; gnt/idx are meaningful only
//           while valid is high (there is no ready side: the consumer samples
//           the result in the same cycle it decides to grant)
//   gnt   : one-hot grant
//   idx   : binary index of gnt
module rr_arbiter
  import pulse_rr_sched_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx
);

  int               shift;
  logic [N_REQ-1:0] rot;
  logic [N_REQ-1:0] rot_gnt;

  // Rotate so that requester last+1 sits at bit 0, isolate the lowest set
  // bit, then rotate the result back into requester positions.
  always_comb begin
    shift   = int'(last) + 1;
    rot     = N_REQ'({req, req} >> shift);
    rot_gnt = rot & (~rot + N_REQ'(1));
    gnt     = N_REQ'(({rot_gnt, rot_gnt} << shift) >> N_REQ);
    valid   = |req;
    idx     = IDX_W'(onehot_to_idx(8'(gnt)));
  end

endmodule

// File: rtl/pulse_rr_sched.sv
// pulse_rr_sched
// Shares one LED pulse among N_REQ requesters. Rising edges on req_i are
// latched as pending; a round-robin scheduler serves them one at a time with
// a PULSE_CYCLES-wide pulse followed by a GAP_CYCLES guard gap.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   req_i          : synchronized button levels
//   count_sel_i    : selects the requester whose served count drives count_o
//   pulse_o        : shared registered pulse
//   grant_o        : one-hot requester being pulsed (registered)
//   grant_id_o     : index of the last/current grant, held in IDLE and GAP
//   pending_o      : latched, not-yet-served requests
//   busy_o         : high in PULSE or GAP
//   done_o         : strobe on the final PULSE cycle
//   count_o        : served count of the selected requester
//   state_o        : scheduler state, for observation
// Optional feature: define PULSE_RR_COUNT_EN to build the per-requester
// saturating served counters; otherwise count_o is tied to 0.
module pulse_rr_sched
  import pulse_rr_sched_pkg::*;
#(
  parameter  int N_REQ        = 4,
  parameter  int PULSE_CYCLES = 8,
  parameter  int GAP_CYCLES   = 2,
  parameter  int CNT_W        = 8,
  localparam int IDX_W        = $clog2(N_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [IDX_W-1:0]   count_sel_i,
  output logic               pulse_o,
  output logic [N_REQ-1:0]   grant_o,
  output logic [IDX_W-1:0]   grant_id_o,
  output logic [N_REQ-1:0]   pending_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [COUNT_W-1:0] count_o,
  output sched_state_t       state_o
);

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  sched_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] req_q;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             pulse_q, pulse_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] grant_id_q, grant_id_d;
  logic [N_REQ-1:0] rise;
  logic [N_REQ-1:0] clr;
  logic             arb_valid;
  logic [N_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0] arb_idx;

  assign rise = req_i & ~req_q;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req   (pending_q),
    .last  (last_q),
    .valid (arb_valid),
    .gnt   (arb_gnt),
    .idx   (arb_idx)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pulse_d    = pulse_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    last_d     = last_q;
    clr        = '0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d    = PULSE;
          cnt_d      = PULSE_LOAD;
          pulse_d    = 1'b1;
          grant_d    = arb_gnt;
          grant_id_d = arb_idx;
          last_d     = arb_idx;
          clr        = arb_gnt;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          pulse_d = 1'b0;
          grant_d = '0;
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    // A rise in the same cycle as the grant re-arms the request.
    pending_d = (pending_q & ~clr) | rise;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      pending_q  <= '0;
      last_q     <= IDX_W'(N_REQ - 1);
      pulse_q    <= 1'b0;
      grant_q    <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_i;
      pending_q  <= pending_d;
      last_q     <= last_d;
      pulse_q    <= pulse_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign pulse_o    = pulse_q;
  assign grant_o    = grant_q;
  assign grant_id_o = grant_id_q;
  assign pending_o  = pending_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == PULSE) && (cnt_q == '0);
  assign state_o    = state_q;

`ifdef PULSE_RR_COUNT_EN
  logic [COUNT_W-1:0] served_q [N_REQ];
  logic [COUNT_W-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < N_REQ; k++) served_q[k] <= '0;
      count_q <= '0;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if (clr[k] && (served_q[k] != '1)) served_q[k] <= served_q[k] + COUNT_W'(1);
      end
      if (int'(count_sel_i) < N_REQ) count_q <= served_q[count_sel_i];
      else                           count_q <= '0;
    end
  end

  assign count_o = count_q;
`else
  logic unused_sel;
  assign unused_sel = ^count_sel_i;
  assign count_o    = '0;
`endif

endmodule

// File: tb/tb_pulse_rr_sched.sv
// tb_pulse_rr_sched
// Directed bench for pulse_rr_sched with default parameters
// (N_REQ=4, PULSE_CYCLES=8, GAP_CYCLES=2). Inputs are driven and outputs
// sampled on the falling clock edge; the design acts on the rising edge.
module tb_pulse_rr_sched;
  import pulse_rr_sched_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [1:0]   count_sel;
  logic         pulse;
  logic [3:0]   grant;
  logic [1:0]   grant_id;
  logic [3:0]   pending;
  logic         busy;
  logic         done;
  logic [7:0]   count;
  sched_state_t state;

  int errors = 0;
  int checks = 0;

  pulse_rr_sched #(
    .N_REQ(4), .PULSE_CYCLES(8), .GAP_CYCLES(2), .CNT_W(8)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_i       (req),
    .count_sel_i (count_sel),
    .pulse_o     (pulse),
    .grant_o     (grant),
    .grant_id_o  (grant_id),
    .pending_o   (pending),
    .busy_o      (busy),
    .done_o      (done),
    .count_o     (count),
    .state_o     (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || pending != 4'b0000) && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (busy || pending != 4'b0000) begin
      errors++;
      $display("FAIL wait_idle: busy=%b pending=%b after %0d cycles, required idle", busy, pending, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = '0;
    count_sel = 2'd0;
    tick();
    checks++;
    if ({pulse, grant, grant_id, pending, busy, done, count} !== '0 || state !== IDLE) begin
      errors++;
      $display("FAIL reset_outputs: pulse=%b grant=%b id=%0d pending=%b busy=%b done=%b count=%0d state=%0d, required all 0",
               pulse, grant, grant_id, pending, busy, done, count, state);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    apply_reset();
    req = 4'b0100;
    tick();
    checks++;
    if (pending !== 4'b0100 || pulse !== 1'b0) begin
      errors++;
      $display("FAIL single_pending: pending=%b pulse=%b, required 0100 and 0", pending, pulse);
    end
    tick();
    checks++;
    if (grant !== 4'b0100 || grant_id !== 2'd2 || pending !== 4'b0000 || !busy || state !== PULSE) begin
      errors++;
      $display("FAIL single_grant: grant=%b id=%0d pending=%b busy=%b state=%0d, required 0100 2 0000 1 PULSE",
               grant, grant_id, pending, busy, state);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (pulse !== 1'b1 || done !== (i == 7)) begin
        errors++;
        $display("FAIL single_pulse[%0d]: pulse=%b done=%b, required 1 %b", i, pulse, done, i == 7);
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (pulse !== 1'b0 || busy !== 1'b1 || grant !== 4'b0000 || done !== 1'b0 || grant_id !== 2'd2) begin
        errors++;
        $display("FAIL single_gap[%0d]: pulse=%b busy=%b grant=%b done=%b id=%0d, required 0 1 0000 0 2",
                 i, pulse, busy, grant, done, grant_id);
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0 || state !== IDLE || grant_id !== 2'd2) begin
      errors++;
      $display("FAIL single_idle: busy=%b state=%0d id=%0d, required 0 IDLE 2", busy, state, grant_id);
    end
    req = '0;
    tick();
  endtask

  task automatic test_multi();
    int edges[$];
    int ids[$];
    logic prev;
    apply_reset();
    prev = 1'b0;
    req = 4'b1011;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (i == 0) req = '0;
      if (pulse && !prev) begin
        edges.push_back(i);
        ids.push_back(int'(grant_id));
      end
      prev = pulse;
    end
    checks++;
    if (edges.size() != 3) begin
      errors++;
      $display("FAIL multi_count: %0d pulses, required 3", edges.size());
    end else begin
      checks++;
      if (ids[0] != 0 || ids[1] != 1 || ids[2] != 3) begin
        errors++;
        $display("FAIL multi_order: ids %0d,%0d,%0d, required 0,1,3", ids[0], ids[1], ids[2]);
      end
      checks++;
      if (edges[0] != 1 || edges[1] - edges[0] != 11 || edges[2] - edges[1] != 11) begin
        errors++;
        $display("FAIL multi_spacing: edges at %0d,%0d,%0d, required 1,12,23", edges[0], edges[1], edges[2]);
      end
    end
    wait_idle();
  endtask

  task automatic test_hold();
    int npulse;
    logic prev;
    apply_reset();
    npulse = 0;
    prev = 1'b0;
    req = 4'b0010;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (pulse && !prev) npulse++;
      prev = pulse;
    end
    req = '0;
    checks++;
    if (npulse != 1) begin
      errors++;
      $display("FAIL hold_single_pulse: %0d pulses, required 1", npulse);
    end
    wait_idle();
  endtask

  task automatic test_reentry();
    int ids[$];
    logic prev;
    apply_reset();
    prev = 1'b0;
    req = 4'b0001;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (pulse && !prev) ids.push_back(int'(grant_id));
      prev = pulse;
      if (i == 5) begin
        checks++;
        if (pending !== 4'b1001 || pulse !== 1'b1) begin
          errors++;
          $display("FAIL reentry_pending: pending=%b pulse=%b, required 1001 1", pending, pulse);
        end
      end
      case (i)
        1: req = 4'b0000;
        2: req = 4'b1000;
        3: req = 4'b0000;
        4: req = 4'b0001;
        5: req = 4'b0000;
        default: ;
      endcase
    end
    checks++;
    if (ids.size() != 3) begin
      errors++;
      $display("FAIL reentry_count: %0d pulses, required 3", ids.size());
    end else begin
      checks++;
      if (ids[0] != 0 || ids[1] != 3 || ids[2] != 0) begin
        errors++;
        $display("FAIL reentry_order: ids %0d,%0d,%0d, required 0,3,0", ids[0], ids[1], ids[2]);
      end
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req = 4'b0110;
    tick();
    tick();
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (pulse !== 1'b1 || pending === 4'b0000) begin
      errors++;
      $display("FAIL midreset_setup: pulse=%b pending=%b, required pulse 1 with a pending request", pulse, pending);
    end
    #2;
    rst_n = 1'b0;
    req = '0;
    #1;
    checks++;
    if (pulse !== 1'b0 || pending !== 4'b0000 || busy !== 1'b0 || grant !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_async: pulse=%b pending=%b busy=%b grant=%b, required 0", pulse, pending, busy, grant);
    end
    tick();
    rst_n = 1'b1;
    tick();
    req = 4'b0101;
    tick();
    tick();
    checks++;
    if (pulse !== 1'b1 || grant_id !== 2'd0 || grant !== 4'b0001 || pending !== 4'b0100) begin
      errors++;
      $display("FAIL midreset_first: pulse=%b id=%0d grant=%b pending=%b, required 1 0 0001 0100",
               pulse, grant_id, grant, pending);
    end
    req = '0;
    wait_idle();
  endtask

  task automatic test_count();
    apply_reset();
    count_sel = 2'd1;
    for (int n = 0; n < 300; n++) begin
      req = 4'b0010;
      tick();
      req = '0;
      tick();
      wait_idle();
    end
    tick();
    tick();
`ifdef PULSE_RR_COUNT_EN
    checks++;
    if (count !== 8'd255) begin
      errors++;
      $display("FAIL count_saturate: count=%0d, required 255", count);
    end
    count_sel = 2'd0;
    tick();
    tick();
    checks++;
    if (count !== 8'd0) begin
      errors++;
      $display("FAIL count_other: count=%0d, required 0", count);
    end
`else
    checks++;
    if (count !== 8'd0) begin
      errors++;
      $display("FAIL count_disabled: count=%0d, required 0", count);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0;
    count_sel = '0;
    test_reset();
    test_single();
    test_multi();
    test_hold();
    test_reentry();
    test_reset_mid();
    test_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
